// File: rtl/hilo_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_unit_if
//   Bundle between the EXE multiply/divide stage and the HI/LO register unit.
//   It carries the HI/LO write result leaving EXE and the forwarded HI/LO
//   values that EXE reads back for MFHI/MFLO and for the MADD/MSUB accumulator.
//
//   Handshake: a write is offered by holding exe_advance high together with a
//   non-zero exe_hilo_we for one clock. The transfer happens on that rising
//   edge. The receiver has no ready output and takes one write per cycle. While
//   the pipeline is stalled the producer must keep exe_advance low.
//
//   Signals
//     exe_advance   EXE -> unit  instruction leaves EXE this cycle
//     exe_hilo_we   EXE -> unit  bit1 writes HI, bit0 writes LO
//     exe_hi_wdata  EXE -> unit  HI result
//     exe_lo_wdata  EXE -> unit  LO result
//     fwd_hi        unit -> EXE  youngest HI value visible to EXE
//     fwd_lo        unit -> EXE  youngest LO value visible to EXE
//
//   Modports
//     master  EXE side (drives the write, reads the forwarded values)
//     slave   HI/LO unit side
// -----------------------------------------------------------------------------
interface hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             exe_advance;
    logic [1:0]       exe_hilo_we;
    logic [WIDTH-1:0] exe_hi_wdata;
    logic [WIDTH-1:0] exe_lo_wdata;
    logic [WIDTH-1:0] fwd_hi;
    logic [WIDTH-1:0] fwd_lo;

    modport master (
        output exe_advance,
        output exe_hilo_we,
        output exe_hi_wdata,
        output exe_lo_wdata,
        input  fwd_hi,
        input  fwd_lo
    );

    modport slave (
        input  exe_advance,
        input  exe_hilo_we,
        input  exe_hi_wdata,
        input  exe_lo_wdata,
        output fwd_hi,
        output fwd_lo
    );
endinterface

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//   Architectural HI/LO register pair located just after the EXE multiply/
//   divide unit. HI/LO write results leave EXE and pass through two pending
//   slots, MEM and WB. They commit to the architectural registers at WB. The
//   youngest value of each half is forwarded back to EXE. An exception flush
//   discards every write that has not committed yet.
//
//   Parameters
//     WIDTH      data width of HI and LO
//     RESET_VAL  reset value of the architectural HI and LO registers
//
//   Ports
//     clk           clock, rising edge
//     rst           asynchronous active-high reset
//     exe           hilo_unit_if.slave: EXE write in, fwd_hi/fwd_lo out
//     pipe_stall    MEM/WB hold: slots and architectural registers freeze
//     flush         exception at MEM: kill the MEM slot and the EXE capture
//     arch_hi       committed HI
//     arch_lo       committed LO
//     commit_valid  registered pulse: a commit happened on the previous edge
//     pending_cnt   number of valid pending slots (0..2)
// -----------------------------------------------------------------------------
module hilo_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    hilo_unit_if.slave       exe,
    input  logic             pipe_stall,
    input  logic             flush,
    output logic [WIDTH-1:0] arch_hi,
    output logic [WIDTH-1:0] arch_lo,
    output logic             commit_valid,
    output logic [1:0]       pending_cnt
);

    // A pending slot is valid exactly when its write-enable field is non-zero.
    typedef struct packed {
        logic [1:0]       we;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } slot_t;

    slot_t            mem_q, mem_d;
    slot_t            wb_q,  wb_d;
    logic [WIDTH-1:0] arch_hi_q, arch_hi_d;
    logic [WIDTH-1:0] arch_lo_q, arch_lo_d;
    logic             commit_q,  commit_d;

    logic             mem_valid;
    logic             wb_valid;

    assign mem_valid = |mem_q.we;
    assign wb_valid  = |wb_q.we;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_d     = mem_q;
        wb_d      = wb_q;
        arch_hi_d = arch_hi_q;
        arch_lo_d = arch_lo_q;
        commit_d  = 1'b0;

        if (flush) begin
            // WB is older than the faulting instruction in MEM, so it still
            // commits. Anything younger is discarded. Flush wins over stall.
            if (wb_q.we[1]) arch_hi_d = wb_q.hi;
            if (wb_q.we[0]) arch_lo_d = wb_q.lo;
            commit_d  = wb_valid;
            wb_d.we   = 2'b00;
            mem_d.we  = 2'b00;
        end else if (pipe_stall) begin
            // Every slot holds. exe_advance is ignored because the producer
            // keeps it low while the pipeline is stalled.
            commit_d  = 1'b0;
        end else begin
            if (wb_q.we[1]) arch_hi_d = wb_q.hi;
            if (wb_q.we[0]) arch_lo_d = wb_q.lo;
            commit_d  = wb_valid;
            wb_d      = mem_q;
            if (exe.exe_advance) begin
                mem_d.we = exe.exe_hilo_we;
                mem_d.hi = exe.exe_hi_wdata;
                mem_d.lo = exe.exe_lo_wdata;
            end else begin
                // Only the enables are cleared. The stale data cannot be seen
                // because forwarding and commit are both gated by we.
                mem_d.we = 2'b00;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '0;
            wb_q      <= '0;
            arch_hi_q <= RESET_VAL;
            arch_lo_q <= RESET_VAL;
            commit_q  <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            arch_hi_q <= arch_hi_d;
            arch_lo_q <= arch_lo_d;
            commit_q  <= commit_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: each half independently takes the youngest writer of that
    // half. For example, with MTLO in MEM and MTHI in WB, LO comes from MEM
    // and HI comes from WB.
    // ------------------------------------------------------------------
    always_comb begin
        exe.fwd_hi = arch_hi_q;
        if (mem_q.we[1]) begin
            exe.fwd_hi = mem_q.hi;
        end else if (wb_q.we[1]) begin
            exe.fwd_hi = wb_q.hi;
        end
    end

    always_comb begin
        exe.fwd_lo = arch_lo_q;
        if (mem_q.we[0]) begin
            exe.fwd_lo = mem_q.lo;
        end else if (wb_q.we[0]) begin
            exe.fwd_lo = wb_q.lo;
        end
    end

    assign arch_hi      = arch_hi_q;
    assign arch_lo      = arch_lo_q;
    assign commit_valid = commit_q;
    assign pending_cnt  = {1'b0, mem_valid} + {1'b0, wb_valid};

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//   Directed bench for hilo_unit. The inputs change 1 time unit after a rising
//   edge. The outputs are sampled at that same point, well away from the next
//   edge. Every expected value is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         pipe_stall;
    logic         flush;
    logic [W-1:0] arch_hi;
    logic [W-1:0] arch_lo;
    logic         commit_valid;
    logic [1:0]   pending_cnt;

    int checks;
    int errors;

    hilo_unit_if #(.WIDTH(W)) exe_if ();

    hilo_unit #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk          (clk),
        .rst          (rst),
        .exe          (exe_if.slave),
        .pipe_stall   (pipe_stall),
        .flush        (flush),
        .arch_hi      (arch_hi),
        .arch_lo      (arch_lo),
        .commit_valid (commit_valid),
        .pending_cnt  (pending_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic adv, input logic [1:0] we, input logic [W-1:0] hi, input logic [W-1:0] lo);
        exe_if.exe_advance  = adv;
        exe_if.exe_hilo_we  = we;
        exe_if.exe_hi_wdata = hi;
        exe_if.exe_lo_wdata = lo;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, '0, '0);
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] e_fhi, input logic [W-1:0] e_flo,
                             input logic [W-1:0] e_ahi, input logic [W-1:0] e_alo,
                             input logic e_cv, input logic [1:0] e_pc);
        check({tag, ".fwd_hi"},       exe_if.fwd_hi, e_fhi);
        check({tag, ".fwd_lo"},       exe_if.fwd_lo, e_flo);
        check({tag, ".arch_hi"},      arch_hi, e_ahi);
        check({tag, ".arch_lo"},      arch_lo, e_alo);
        check({tag, ".commit_valid"}, {{(W-1){1'b0}}, commit_valid}, {{(W-1){1'b0}}, e_cv});
        check({tag, ".pending_cnt"},  {{(W-2){1'b0}}, pending_cnt}, {{(W-2){1'b0}}, e_pc});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        pipe_stall = 1'b0;
        flush      = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);

        // 1: a full-width write travels through MEM and WB and commits.
        drive(1'b1, 2'b11, 32'h1111_1111, 32'h2222_2222);
        step();
        idle();
        check_all("t1.mem", 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 1'b0, 2'd1);
        step();
        check_all("t1.wb", 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 1'b0, 2'd1);
        step();
        check_all("t1.commit", 32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 1'b1, 2'd0);
        step();
        check_all("t1.after", 32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 1'b0, 2'd0);

        // 2: MTHI followed by MTLO. Each forwarded half comes from a different slot.
        drive(1'b1, 2'b10, 32'hAAAA_0000, 32'hDEAD_DEAD);
        step();
        check_all("t2.mthi_mem", 32'hAAAA_0000, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 1'b0, 2'd1);
        drive(1'b1, 2'b01, 32'hBEEF_BEEF, 32'h0000_BBBB);
        step();
        idle();
        check_all("t2.split", 32'hAAAA_0000, 32'h0000_BBBB, 32'h1111_1111, 32'h2222_2222, 1'b0, 2'd2);
        step();
        check_all("t2.hi_commit", 32'hAAAA_0000, 32'h0000_BBBB, 32'hAAAA_0000, 32'h2222_2222, 1'b1, 2'd1);
        step();
        check_all("t2.lo_commit", 32'hAAAA_0000, 32'h0000_BBBB, 32'hAAAA_0000, 32'h0000_BBBB, 1'b1, 2'd0);

        // 3: a write sitting in MEM is killed by flush.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive(1'b1, 2'b10, 32'h5, 32'h0);
        step();
        idle();
        check("t3.fwd_hi_mem", exe_if.fwd_hi, 32'h5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_all("t3.flushed", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
        step();
        check_all("t3.after", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);

        // 4: flush with A in WB and B in MEM. A commits; B and the EXE offer are dropped.
        drive(1'b1, 2'b11, 32'h1, 32'h2);
        step();
        drive(1'b1, 2'b11, 32'h3, 32'h4);
        step();
        check_all("t4.loaded", 32'h3, 32'h4, 32'h0, 32'h0, 1'b0, 2'd2);
        drive(1'b1, 2'b11, 32'hDEAD_0001, 32'hBEEF_0002);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check_all("t4.flush", 32'h1, 32'h2, 32'h1, 32'h2, 1'b1, 2'd0);
        step();
        check_all("t4.after", 32'h1, 32'h2, 32'h1, 32'h2, 1'b0, 2'd0);

        // 5: a stall lasting 4 cycles with both slots valid.
        drive(1'b1, 2'b11, 32'h10, 32'h20);
        step();
        drive(1'b1, 2'b11, 32'h30, 32'h40);
        step();
        idle();
        pipe_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all($sformatf("t5.stall%0d", i), 32'h30, 32'h40, 32'h1, 32'h2, 1'b0, 2'd2);
        end
        pipe_stall = 1'b0;
        step();
        check_all("t5.rel1", 32'h30, 32'h40, 32'h10, 32'h20, 1'b1, 2'd1);
        step();
        check_all("t5.rel2", 32'h30, 32'h40, 32'h30, 32'h40, 1'b1, 2'd0);
        step();
        check_all("t5.rel3", 32'h30, 32'h40, 32'h30, 32'h40, 1'b0, 2'd0);

        // 6: reset asserted between edges clears everything at once.
        drive(1'b1, 2'b11, 32'h55, 32'h66);
        step();
        drive(1'b1, 2'b11, 32'h77, 32'h88);
        step();
        idle();
        check_all("t6.loaded", 32'h77, 32'h88, 32'h30, 32'h40, 1'b0, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check_all("t6.async", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
        step();
        rst = 1'b0;
        step();
        check_all("t6.after", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
